// File: rtl/codigo_teclas_fifo.sv
// codigo_teclas_fifo
// Turns a stream of PS/2 scan bytes into key events (plain or E0-extended,
// break and optionally make). Events wait in a small circular FIFO until the
// PicoBlaze reads them. A data port pops the head code. A status port reports
// the FIFO flags and the head event's ext/brk bits, and clears the sticky
// overflow flag.

module codigo_teclas_fifo #(
   parameter int         DEPTH       = 4,
   parameter int         AW          = 2,
   parameter bit         REPORT_MAKE = 1'b0,
   parameter logic [7:0] PORT_DATA   = 8'h0A,
   parameter logic [7:0] PORT_STAT   = 8'h0B
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          scan_done_tick,
   input  logic [7:0]    scan_out,
   input  logic [7:0]    port_id,
   input  logic          read_strobe,
   output logic          got_code_tick,
   output logic [7:0]    dato,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count
);

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK
   } state_t;

   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE    = 1;
   localparam logic [AW-1:0] PTR_ONE    = 1;

   state_t          state;
   logic            ext;

   logic [9:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            overflow;

   logic            is_e0;
   logic            is_f0;
   logic            push_req;
   logic [9:0]      push_entry;
   logic            pop;
   logic            push_ok;
   logic            stat_clear;

   logic [9:0]      head;
   logic [7:0]      head_code;
   logic            head_ext;
   logic            head_brk;

   assign is_e0 = (scan_out == 8'hE0);
   assign is_f0 = (scan_out == 8'hF0);

   // Decide whether the byte arriving now completes an event, and build its entry
   always_comb begin
      push_req   = 1'b0;
      push_entry = {2'b00, scan_out};
      if (scan_done_tick && !is_e0 && !is_f0) begin
         case (state)
            IDLE: begin
               push_req   = REPORT_MAKE;
               push_entry = {1'b0, 1'b0, scan_out};
            end
            EXT: begin
               push_req   = REPORT_MAKE;
               push_entry = {1'b1, 1'b0, scan_out};
            end
            BRK: begin
               push_req   = 1'b1;
               push_entry = {ext, 1'b1, scan_out};
            end
            default: begin
               push_req   = 1'b0;
               push_entry = {2'b00, scan_out};
            end
         endcase
      end
   end

   // Prefix decoder: tracks E0/F0 prefixes, advancing only on received bytes
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ext   <= 1'b0;
      end else if (scan_done_tick) begin
         case (state)
            IDLE: begin
               if (is_e0) begin
                  state <= EXT;
               end else if (is_f0) begin
                  state <= BRK;
                  ext   <= 1'b0;
               end
            end
            EXT: begin
               if (is_f0) begin
                  state <= BRK;
                  ext   <= 1'b1;
               end else if (!is_e0) begin
                  state <= IDLE;
                  ext   <= 1'b0;
               end
            end
            BRK: begin
               if (!is_e0 && !is_f0) begin
                  state <= IDLE;
                  ext   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               ext   <= 1'b0;
            end
         endcase
      end
   end

   assign empty      = (count == '0);
   assign full       = (count == FULL_COUNT);
   assign pop        = (port_id == PORT_DATA) && read_strobe && !empty;
   assign push_ok    = push_req && (!full || pop);
   assign stat_clear = (port_id == PORT_STAT) && read_strobe;

   assign head      = mem[rd_ptr];
   assign head_code = empty ? 8'h00 : head[7:0];
   assign head_ext  = empty ? 1'b0  : head[9];
   assign head_brk  = empty ? 1'b0  : head[8];

   // Storage array; stale entries are never visible because reads are masked by empty
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Pointer, occupancy, overflow and write-pulse bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         overflow      <= 1'b0;
         got_code_tick <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (push_req && !push_ok) begin
            overflow <= 1'b1;
         end else if (stat_clear) begin
            overflow <= 1'b0;
         end
         got_code_tick <= push_ok;
      end
   end

   // Read mux registered every cycle so the PicoBlaze sees data one cycle after port_id
   always_ff @(posedge clk) begin
      if (reset) begin
         dato <= 8'h00;
      end else if (port_id == PORT_DATA) begin
         dato <= head_code;
      end else if (port_id == PORT_STAT) begin
         dato <= {overflow, empty, full, 3'b000, head_ext, head_brk};
      end else begin
         dato <= 8'h00;
      end
   end

endmodule

// File: tb/tb_codigo_teclas_fifo.sv
// tb_codigo_teclas_fifo
// Directed bench: a per-cycle vector table for decoding and port reads, and
// hand-written sequences for overflow, push/pop collisions, pointer wrap,
// and reset. A second instance with make reporting enabled shares the inputs.

module tb_codigo_teclas_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scan_done_tick = 1'b0;
   logic [7:0] scan_out = 8'h00;
   logic [7:0] port_id = 8'h00;
   logic       read_strobe = 1'b0;

   logic       got_code_tick;
   logic [7:0] dato;
   logic       empty;
   logic       full;
   logic [2:0] count;

   logic       got_mk;
   logic [7:0] dato_mk;
   logic       empty_mk;
   logic       full_mk;
   logic [2:0] count_mk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       tk;
      logic [7:0] sc;
      logic [7:0] pid;
      logic       rs;
      logic       exp_got;
      logic [7:0] exp_dato;
      logic [2:0] exp_count;
   } vec_t;

   vec_t vecs[$];

   codigo_teclas_fifo #(
      .DEPTH(4), .AW(2), .REPORT_MAKE(1'b0), .PORT_DATA(8'h0A), .PORT_STAT(8'h0B)
   ) dut (
      .clk(clk), .reset(reset), .scan_done_tick(scan_done_tick), .scan_out(scan_out),
      .port_id(port_id), .read_strobe(read_strobe), .got_code_tick(got_code_tick),
      .dato(dato), .empty(empty), .full(full), .count(count)
   );

   codigo_teclas_fifo #(
      .DEPTH(4), .AW(2), .REPORT_MAKE(1'b1), .PORT_DATA(8'h0A), .PORT_STAT(8'h0B)
   ) dut_mk (
      .clk(clk), .reset(reset), .scan_done_tick(scan_done_tick), .scan_out(scan_out),
      .port_id(port_id), .read_strobe(read_strobe), .got_code_tick(got_mk),
      .dato(dato_mk), .empty(empty_mk), .full(full_mk), .count(count_mk)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%02h expected=%02h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at a falling edge and wait for the next falling edge
   task automatic applyStimulus(input logic tk, input logic [7:0] sc,
                                input logic [7:0] pid, input logic rs);
      scan_done_tick = tk;
      scan_out       = sc;
      port_id        = pid;
      read_strobe    = rs;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic exp_got,
                              input logic [7:0] exp_dato, input logic [2:0] exp_count);
      check({name, ".tick"},  {7'b0, got_code_tick}, {7'b0, exp_got});
      check({name, ".dato"},  dato, exp_dato);
      check({name, ".count"}, {5'b0, count}, {5'b0, exp_count});
      check({name, ".empty"}, {7'b0, empty}, {7'b0, (exp_count == 3'd0)});
      check({name, ".full"},  {7'b0, full},  {7'b0, (exp_count == 3'd4)});
   endtask

   task automatic doReset(input string name);
      reset = 1'b1;
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      reset = 1'b0;
      checkOutput(name, 1'b0, 8'h00, 3'd0);
      check({name, ".mk_count"}, {5'b0, count_mk}, 8'h00);
   endtask

   task automatic sendBreak(input string name, input logic [7:0] code,
                            input logic exp_got, input logic [2:0] cnt_before,
                            input logic [2:0] cnt_after);
      applyStimulus(1'b1, 8'hF0, 8'h00, 1'b0);
      checkOutput({name, ".f0"}, 1'b0, 8'h00, cnt_before);
      applyStimulus(1'b1, code, 8'h00, 1'b0);
      checkOutput({name, ".code"}, exp_got, 8'h00, cnt_after);
   endtask

   initial begin
      // tk, sc, pid, rs, got, dato, count
      vecs.push_back('{1'b1, 8'h1C, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'hF0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'h1C, 8'h00, 1'b0, 1'b1, 8'h00, 3'd1});
      vecs.push_back('{1'b0, 8'h00, 8'h0B, 1'b0, 1'b0, 8'h01, 3'd1});
      vecs.push_back('{1'b0, 8'h00, 8'h0C, 1'b1, 1'b0, 8'h00, 3'd1});
      vecs.push_back('{1'b0, 8'h00, 8'h0A, 1'b1, 1'b0, 8'h1C, 3'd0});
      vecs.push_back('{1'b0, 8'h00, 8'h0A, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'hE0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'hF0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'h75, 8'h00, 1'b0, 1'b1, 8'h00, 3'd1});
      vecs.push_back('{1'b0, 8'h00, 8'h0B, 1'b0, 1'b0, 8'h03, 3'd1});
      vecs.push_back('{1'b0, 8'h00, 8'h0A, 1'b1, 1'b0, 8'h75, 3'd0});
      vecs.push_back('{1'b0, 8'h00, 8'h0B, 1'b0, 1'b0, 8'h40, 3'd0});
      vecs.push_back('{1'b1, 8'hF0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'hE0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'hF0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'h2B, 8'h00, 1'b0, 1'b1, 8'h00, 3'd1});
      vecs.push_back('{1'b0, 8'h00, 8'h0B, 1'b0, 1'b0, 8'h01, 3'd1});
      vecs.push_back('{1'b0, 8'h00, 8'h0A, 1'b1, 1'b0, 8'h2B, 3'd0});
      vecs.push_back('{1'b1, 8'hE0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'hE0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'hF0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'h6B, 8'h00, 1'b0, 1'b1, 8'h00, 3'd1});
      vecs.push_back('{1'b0, 8'h00, 8'h0B, 1'b0, 1'b0, 8'h03, 3'd1});
      vecs.push_back('{1'b0, 8'h00, 8'h0A, 1'b1, 1'b0, 8'h6B, 3'd0});
      vecs.push_back('{1'b1, 8'hE0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'h75, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'hF0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0});
      vecs.push_back('{1'b1, 8'h12, 8'h00, 1'b0, 1'b1, 8'h00, 3'd1});
      vecs.push_back('{1'b0, 8'h00, 8'h0B, 1'b0, 1'b0, 8'h01, 3'd1});
      vecs.push_back('{1'b0, 8'h00, 8'h0A, 1'b1, 1'b0, 8'h12, 3'd0});

      @(negedge clk);
      doReset("reset0");

      // Decoding and port reads, one table row per clock
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].tk, vecs[i].sc, vecs[i].pid, vecs[i].rs);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_got, vecs[i].exp_dato,
                     vecs[i].exp_count);
      end

      // Overflow: five break events into a four-entry FIFO
      doReset("reset_ovf");
      for (int i = 0; i < 5; i++) begin
         sendBreak($sformatf("ovf%0d", i), 8'h21 + 8'(i), (i < 4),
                   (i < 4) ? 3'(i) : 3'd4, (i < 4) ? 3'(i + 1) : 3'd4);
      end
      // A new overflow in the same cycle as a status clear keeps the flag set
      applyStimulus(1'b1, 8'hF0, 8'h00, 1'b0);
      checkOutput("ovfwin.f0", 1'b0, 8'h00, 3'd4);
      applyStimulus(1'b1, 8'h27, 8'h0B, 1'b1);
      checkOutput("ovfwin.code", 1'b0, 8'hA1, 3'd4);
      applyStimulus(1'b0, 8'h00, 8'h0B, 1'b0);
      checkOutput("ovfwin.stat", 1'b0, 8'hA1, 3'd4);
      applyStimulus(1'b0, 8'h00, 8'h0B, 1'b1);
      checkOutput("ovf.clear", 1'b0, 8'hA1, 3'd4);
      applyStimulus(1'b0, 8'h00, 8'h0B, 1'b0);
      checkOutput("ovf.cleared", 1'b0, 8'h21, 3'd4);

      // Full FIFO: pop in the same cycle a break completes
      applyStimulus(1'b1, 8'hF0, 8'h00, 1'b0);
      checkOutput("fullpp.f0", 1'b0, 8'h00, 3'd4);
      applyStimulus(1'b1, 8'h26, 8'h0A, 1'b1);
      checkOutput("fullpp.code", 1'b1, 8'h21, 3'd4);
      applyStimulus(1'b0, 8'h00, 8'h0B, 1'b0);
      checkOutput("fullpp.stat", 1'b0, 8'h21, 3'd4);
      begin
         logic [7:0] order [4];
         order[0] = 8'h22; order[1] = 8'h23; order[2] = 8'h24; order[3] = 8'h26;
         for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 8'h0A, 1'b1);
            checkOutput($sformatf("fullpp.drain%0d", i), 1'b0, order[i], 3'(3 - i));
         end
      end

      // Three fill/drain rounds so both pointers wrap
      doReset("reset_wrap");
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 4; j++) begin
            sendBreak($sformatf("wrap%0d.fill%0d", r, j), 8'h30 + 8'(4 * r + j),
                      1'b1, 3'(j), 3'(j + 1));
         end
         for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 8'h00, 8'h0A, 1'b1);
            checkOutput($sformatf("wrap%0d.drain%0d", r, j), 1'b0,
                        8'h30 + 8'(4 * r + j), 3'(3 - j));
         end
      end
      applyStimulus(1'b0, 8'h00, 8'h0A, 1'b1);
      checkOutput("emptyread", 1'b0, 8'h00, 3'd0);
      // Empty FIFO: pop ignored, push still accepted
      applyStimulus(1'b1, 8'hF0, 8'h00, 1'b0);
      checkOutput("emptypp.f0", 1'b0, 8'h00, 3'd0);
      applyStimulus(1'b1, 8'h55, 8'h0A, 1'b1);
      checkOutput("emptypp.code", 1'b1, 8'h00, 3'd1);
      applyStimulus(1'b0, 8'h00, 8'h0A, 1'b1);
      checkOutput("emptypp.pop", 1'b0, 8'h55, 3'd0);

      // Reset between F0 and its code byte drops the prefix
      doReset("reset_mid0");
      applyStimulus(1'b1, 8'hF0, 8'h00, 1'b0);
      checkOutput("mid.f0", 1'b0, 8'h00, 3'd0);
      doReset("reset_mid1");
      applyStimulus(1'b1, 8'h1C, 8'h00, 1'b0);
      checkOutput("mid.1c", 1'b0, 8'h00, 3'd0);
      sendBreak("mid.after", 8'h1C, 1'b1, 3'd0, 3'd1);
      doReset("reset_queue");

      // Make reporting instance
      applyStimulus(1'b1, 8'hE0, 8'h00, 1'b0);
      check("mk.e0.tick", {7'b0, got_mk}, 8'h00);
      applyStimulus(1'b1, 8'h75, 8'h00, 1'b0);
      check("mk.75.tick", {7'b0, got_mk}, 8'h01);
      check("mk.75.count", {5'b0, count_mk}, 8'h01);
      check("mk.75.main_count", {5'b0, count}, 8'h00);
      applyStimulus(1'b0, 8'h00, 8'h0B, 1'b0);
      check("mk.stat", dato_mk, 8'h02);
      applyStimulus(1'b1, 8'h1C, 8'h00, 1'b0);
      check("mk.1c.tick", {7'b0, got_mk}, 8'h01);
      check("mk.1c.count", {5'b0, count_mk}, 8'h02);
      applyStimulus(1'b0, 8'h00, 8'h0A, 1'b1);
      check("mk.pop0", dato_mk, 8'h75);
      applyStimulus(1'b0, 8'h00, 8'h0A, 1'b1);
      check("mk.pop1", dato_mk, 8'h1C);
      check("mk.empty", {7'b0, empty_mk}, 8'h01);
      check("mk.full", {7'b0, full_mk}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
